// File: rtl/pwm_pkg.sv
// Shared PWM definitions: FSM state encoding and default sizing, also used
// by the output-mode FSM top level.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

    localparam int PWM_DATA_W   = 8;
    localparam int PWM_PRESCALE = 4;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler producing one PWM tick every PRESCALE clocks. Held at zero
// while clear is high so a period always starts from a fresh prescale phase.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    // Keep at least one bit so PRESCALE = 1 still elaborates cleanly.
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescaler;

    assign tick = ~clear && (prescaler == PS_LAST);

    // Prescaler counts up and wraps on tick; clear forces it back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (clear || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: single-entry sample buffer, period counter, IDLE/RUN
// FSM and duty compare. New duty values only land on a period boundary
// (or immediately while idle) so no period is ever truncated.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int DATA_W   = PWM_DATA_W,
    parameter int PRESCALE = PWM_PRESCALE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pwm_enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DATA_W-1:0] duty_active
);

    localparam logic [DATA_W-1:0] CNT_MAX = {DATA_W{1'b1}};

    pwm_state_e        state, state_nxt;
    logic              run;
    logic              tick;
    logic              boundary;
    logic [DATA_W-1:0] cnt;
    logic              pend_full;
    logic [DATA_W-1:0] pend_data;
    logic              accept;
    logic              consume;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state simply follows the enable from the output-mode FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pwm_enable)  state_nxt = RUN;
            RUN:     if (!pwm_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM decoded output: counters only advance while running.
    always_comb begin
        run = 1'b0;
        if (state == RUN) run = 1'b1;
    end

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~run),
        .tick    (tick)
    );

    assign boundary     = tick && (cnt == CNT_MAX);
    assign sample_ready = ~pend_full;
    assign accept       = sample_valid && ~pend_full;
    // Accept needs an empty buffer, so accept and consume never coincide.
    assign consume      = pend_full && (~run || boundary);

    // Period counter: held at zero in IDLE, natural wrap at 2^DATA_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  cnt <= '0;
        else if (!run) cnt <= '0;
        else if (tick) cnt <= cnt + 1'b1;
    end

    // Holding buffer and applied duty; idle drains every cycle so the
    // latest sample is already applied when RUN begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_full   <= 1'b0;
            pend_data   <= '0;
            duty_active <= '0;
        end else if (accept) begin
            pend_full   <= 1'b1;
            pend_data   <= sample_data;
        end else if (consume) begin
            pend_full   <= 1'b0;
            duty_active <= pend_data;
        end
    end

    // Registered PWM compare and period-start pulse. The boundary term is
    // gated by enable so the pulse never lands in a cycle spent in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= pwm_enable && run && (cnt < duty_active);
            period_start <= pwm_enable && (run ? boundary : 1'b1);
        end
    end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage (DATA_W = 8, PRESCALE = 4, 1024-clock
// period). Expected high-times are hand computed as duty * PRESCALE.
module tb_pwm_output_stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pwm_enable;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_ready;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;

    int n_checks = 0;
    int n_fail   = 0;
    int h, n;

    pwm_output_stage #(.DATA_W(8), .PRESCALE(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pwm_enable   (pwm_enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next negedge carrying a period_start pulse (bounded).
    task automatic wait_ps(input string tag);
        int k = 0;
        @(negedge clk);
        while (!period_start && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ps_seen"}, 32'(period_start), 1);
    endtask

    // Called on a period_start negedge; counts high cycles up to the next one.
    task automatic measure(output int hi, output int len);
        hi  = 0;
        len = 0;
        do begin
            hi += int'(pwm_out);
            len++;
            @(negedge clk);
        end while (!period_start && len < 3000);
    endtask

    // Called at a negedge; holds valid until accepted, returns at a negedge.
    task automatic send(input logic [7:0] d);
        int k = 0;
        sample_valid = 1'b1;
        sample_data  = d;
        while (!sample_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", 32'(sample_ready), 1);
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        pwm_enable   = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(sample_ready), 1);
        check("rst_pwm",   32'(pwm_out),      0);
        check("rst_ps",    32'(period_start), 0);
        check("rst_duty",  32'(duty_active),  0);
        reset_n = 1'b1;
        @(negedge clk);

        // Sample loaded while idle is applied before RUN.
        send(8'd64);
        @(negedge clk);
        check("idle_duty",  32'(duty_active),  64);
        check("idle_ready", 32'(sample_ready), 1);
        check("idle_ps",    32'(period_start), 0);
        check("idle_pwm",   32'(pwm_out),      0);
        pwm_enable = 1'b1;
        @(negedge clk);
        check("first_run_ps", 32'(period_start), 1);
        measure(h, n);
        check("d64_p1_high", 32'(h), 256);
        check("d64_p1_len",  32'(n), 1024);
        measure(h, n);
        check("d64_p2_high", 32'(h), 256);
        check("d64_p2_len",  32'(n), 1024);

        // Mid-period update waits for the boundary.
        fork
            measure(h, n);
            begin
                repeat (300) @(negedge clk);
                send(8'd192);
                check("mid_ready_low", 32'(sample_ready), 0);
            end
        join
        check("mid_cur_high", 32'(h), 256);
        check("mid_ready_back", 32'(sample_ready), 1);
        check("mid_duty", 32'(duty_active), 192);
        measure(h, n);
        check("d192_high", 32'(h), 768);

        // Back-to-back 10 then 20: 20 stalls until the boundary.
        repeat (100) @(negedge clk);
        send(8'd10);
        check("b2b_stall0", 32'(sample_ready), 0);
        sample_valid = 1'b1;
        sample_data  = 8'd20;
        repeat (50) @(negedge clk);
        check("b2b_stall1", 32'(sample_ready), 0);
        check("b2b_duty_old", 32'(duty_active), 192);
        wait_ps("b2b_a");
        check("b2b_ready_a", 32'(sample_ready), 1);
        check("b2b_duty10",  32'(duty_active), 10);
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        check("b2b_20_held", 32'(sample_ready), 0);
        wait_ps("b2b_b");
        check("b2b_duty20", 32'(duty_active), 20);
        measure(h, n);
        check("d20_high", 32'(h), 80);

        // Duty extremes.
        send(8'd0);
        wait_ps("d0");
        check("d0_duty", 32'(duty_active), 0);
        measure(h, n);
        check("d0_high", 32'(h), 0);
        send(8'd255);
        wait_ps("d255");
        measure(h, n);
        check("d255_high", 32'(h), 1020);
        check("d255_len",  32'(n), 1024);

        // Disable mid high pulse, then re-enable.
        repeat (10) @(negedge clk);
        check("dis_pre_high", 32'(pwm_out), 1);
        pwm_enable = 1'b0;
        @(negedge clk);
        check("dis_pwm", 32'(pwm_out), 0);
        check("dis_ps",  32'(period_start), 0);
        repeat (5) @(negedge clk);
        check("dis_cnt", 32'(dut.cnt), 0);
        check("dis_pre", 32'(dut.u_tick.prescaler), 0);
        check("dis_ps2", 32'(period_start), 0);
        pwm_enable = 1'b1;
        @(negedge clk);
        check("reen_ps", 32'(period_start), 1);
        measure(h, n);
        check("reen_high", 32'(h), 1020);
        check("reen_len",  32'(n), 1024);

        // Async reset mid-period with a full buffer.
        send(8'd50);
        check("rst2_full", 32'(sample_ready), 0);
        repeat (20) @(negedge clk);
        check("rst2_pre_high", 32'(pwm_out), 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst2_pwm",   32'(pwm_out),      0);
        check("rst2_ready", 32'(sample_ready), 1);
        check("rst2_duty",  32'(duty_active),  0);
        check("rst2_ps",    32'(period_start), 0);
        pwm_enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst2_lost",   32'(duty_active),  0);
        check("rst2_ready2", 32'(sample_ready), 1);
        check("rst2_pwm2",   32'(pwm_out),      0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
- Downstream consumer of `pwm_enable` from the output-mode FSM.
- Converts conditioned ADC samples into a fixed-frequency, duty-cycle-modulated PWM waveform for the RC-filtered analog output.
- Samples arrive over a valid/ready handshake into a single-entry holding buffer.
- A new duty value takes effect only at a PWM period boundary, so a period is never truncated or glitched.

Parameters:
- DATA_W, 8, sample width and PWM resolution; period = 2^DATA_W ticks.
- PRESCALE, 4, clocks per PWM tick (≥1); period = PRESCALE·2^DATA_W clocks.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pwm_enable  in  1  from output-mode FSM; high = generate PWM.
- sample_valid  in  1  upstream sample valid.
- sample_data  in  DATA_W  unsigned sample; duty = sample_data / 2^DATA_W.
- sample_ready  out  1  buffer empty, can accept a sample.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  one-cycle pulse on the first clock of each period.
- duty_active  out  DATA_W  duty value currently applied.

Behaviour:
- Reset (reset_n low, async):
  - State = IDLE.
  - Prescaler, period counter `cnt`, duty_active, pending buffer all = 0.
  - pwm_out = 0, period_start = 0, sample_ready = 1.
  - Reset mid-period aborts the period immediately. No sample is retained.
- Handshake:
  - sample_ready = ~pend_full.
  - Accept when sample_valid && sample_ready: pend_data <= sample_data, pend_full <= 1.
  - While full, sample_ready = 0 and upstream must hold its data.
- FSM states IDLE and RUN:
  - IDLE -> RUN when pwm_enable = 1.
  - RUN -> IDLE when pwm_enable = 0.
  - Transitions take effect at the next clock.
- IDLE:
  - Prescaler and cnt held at 0. pwm_out = 0.
  - If pend_full: duty_active <= pend_data, pend_full <= 0. The buffer drains every cycle, so the latest sample applies on enable.
- RUN:
  - tick = (prescaler == PRESCALE-1). The prescaler wraps to 0 on tick.
  - On tick, cnt <= cnt+1, wrapping modulo 2^DATA_W.
  - boundary = tick && cnt == 2^DATA_W-1.
  - On boundary, if pend_full: duty_active <= pend_data, pend_full <= 0.
- Simultaneous accept and boundary are impossible: accept requires pend_full = 0, so there is nothing to consume. The accepted sample applies at the next boundary.
- period_start:
  - Asserted for the clock cycle following a boundary.
  - Also asserted for the first RUN cycle after IDLE.
  - Never asserted in IDLE.
- pwm_out:
  - Register: pwm_out <= pwm_enable && (state == RUN) && (cnt < duty_active).
  - Latency of one clock from cnt/duty_active.
  - Falls one clock after pwm_enable deasserts.
- Duty extremes:
  - duty 0 gives pwm_out constantly 0.
  - duty 2^DATA_W-1 gives high for (2^DATA_W-1)·PRESCALE clocks per period.
  - 100% duty is unreachable by design.
- Comparison is unsigned, DATA_W bits. No arithmetic overflow beyond the defined counter wraps.

Decomposition:
- Shared package `pwm_pkg`:
  - state enum (IDLE = 1'b0, RUN = 1'b1).
  - default DATA_W/PRESCALE constants, used by the output-mode FSM top-level as well.
- One sub-module `pwm_tick_gen`:
  - prescaler counter producing `tick`, parameterised by PRESCALE.
  - cleared by an IDLE/clear input.
- Holding buffer, counter, FSM and compare stay in the top module.

Test Plan (DATA_W = 8, PRESCALE = 4, period = 1024 clocks):
- Enable, send sample 64 while IDLE -> duty_active = 64 before RUN; in RUN pwm_out high exactly 256 clocks per 1024-clock period; period_start every 1024 clocks.
- RUN at duty 64, send 192 mid-period -> sample_ready drops for the rest of the period; current period stays 256 high; next period 768 high; sample_ready returns 1 the cycle after the boundary.
- Back-to-back valid 10 then 20 in RUN -> 10 accepted, 20 stalled (sample_ready = 0) until boundary; 10 applies first, 20 the period after.
- duty 0 -> pwm_out never high; duty 255 -> high 1020 of every 1024 clocks.
- Deassert pwm_enable mid-high pulse -> pwm_out 0 one clock later; cnt/prescaler 0; on re-enable period_start pulses on the first RUN cycle and the period restarts from cnt 0.
- Assert reset_n low mid-period with buffer full -> all outputs 0 asynchronously, sample_ready = 1, duty_active = 0, pending sample lost.
